knap_search: RTL and testbench
==============================

KNAP_SEARCH -- requirements
Module: knap_search

Interface
REQ-001 Parameter N_ITEMS, default 5, number of items (1..8); candidate selection width.
REQ-002 Parameter VAL_W, default 8, per-item value width.
REQ-003 Parameter WT_W, default 8, per-item weight width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a search; accepted only in IDLE.
REQ-007 item_values  input  N_ITEMS*VAL_W  packed item values; item i at bits [i*VAL_W +: VAL_W].
REQ-008 item_weights  input  N_ITEMS*WT_W  packed item weights, same packing.
REQ-009 min_value  input  VAL_W+3  minimum acceptable total value.
REQ-010 max_weight  input  WT_W+3  maximum acceptable total weight.
REQ-011 busy  output  1  high in SEARCH and DONE.
REQ-012 done  output  1  one-cycle pulse; results valid from this cycle until the next accepted start.
REQ-013 found  output  1  at least one candidate was valid.
REQ-014 best_sel  output  N_ITEMS  winning selection; bit i selects item i.
REQ-015 best_value  output  VAL_W+3  total value of best_sel.
REQ-016 best_weight  output  WT_W+3  total weight of best_sel.

Function
REQ-017 States IDLE, SEARCH, DONE; IDLE->SEARCH on start; SEARCH->DONE after final candidate; DONE->IDLE unconditionally after one cycle.
REQ-018 On start accepted, item_values, item_weights, min_value and max_weight are registered; later input changes do not affect the running search.
REQ-019 On start accepted, the candidate counter is set to 0 and found, best_sel, best_value and best_weight are cleared to 0.
REQ-020 SEARCH evaluates one candidate per cycle in ascending order 0 .. 2^N_ITEMS-1; candidate k is evaluated in cycle k+1 after the accepting edge.
REQ-021 A candidate's total value and total weight are the zero-extended sums of the selected items' values and weights, at widths VAL_W+3 and WT_W+3; these sums never overflow.
REQ-022 A candidate is valid when total value >= min_value and total weight <= max_weight (unsigned comparison).
REQ-023 A valid candidate replaces the held best when found=0, when its value is strictly greater, or when its value is equal and its weight is strictly lower; otherwise the earlier candidate is kept.
REQ-024 The counter does not wrap: after candidate 2^N_ITEMS-1 the FSM enters DONE, and done is asserted in cycle 2^N_ITEMS+1 after the accepting edge.
REQ-025 If no candidate is valid, the block still asserts done, with found=0 and best_sel, best_value and best_weight all 0.
REQ-026 start while busy is ignored; start in the same cycle as the DONE->IDLE transition is also ignored, and start is first accepted in IDLE.
REQ-027 Output results are held stable in IDLE until the next accepted start.

Reset
REQ-028 rst takes priority over every other input; the next state is IDLE and busy, done, found, best_sel, best_value, best_weight and the candidate counter are all 0.
REQ-029 rst during SEARCH or DONE aborts the search; no done pulse is produced for the aborted search.

Configuration
REQ-030 Macro KNAP_EARLY_EXIT_EN, defined: SEARCH enters DONE in the cycle after the first valid candidate is found; best_sel is that candidate and no later candidates are evaluated.
REQ-031 Macro KNAP_EARLY_EXIT_EN, undefined: the block always performs the full enumeration with best-value selection per REQ-023.

Verification
REQ-032 Inputs: values {4,2,2,1,10}, weights {12,1,2,1,4} (item0..4), min_value 15, max_weight 16; start at cycle 0 -> done at cycle 33 with found=1, best_sel=5'b11110, best_value=15, best_weight=8.
REQ-033 Same inputs with KNAP_EARLY_EXIT_EN defined -> done at cycle 32 with best_sel=5'b11110, found=1.
REQ-034 Same items, min_value 0, max_weight 0 -> found=1, best_sel=0, best_value=0, best_weight=0.
REQ-035 Same items, min_value 200 -> done at cycle 33 with found=0 and all best outputs 0.
REQ-036 start pulsed at cycle 5 and again at cycle 33 -> both ignored, exactly one done at cycle 33; rst at cycle 10 of a new search -> busy=0 next cycle and no done pulse.

Source files
------------

// File: rtl/knap_search.sv
// Exhaustive 0/1 knapsack search: enumerates every item subset, keeps the best valid one.
// Optional KNAP_EARLY_EXIT_EN stops at the first valid subset instead of searching all.
module knap_search #(
    parameter int unsigned N_ITEMS = 5,
    parameter int unsigned VAL_W   = 8,
    parameter int unsigned WT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_ITEMS*VAL_W-1:0]   item_values,
    input  logic [N_ITEMS*WT_W-1:0]    item_weights,
    input  logic [VAL_W+2:0]           min_value,
    input  logic [WT_W+2:0]            max_weight,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [N_ITEMS-1:0]         best_sel,
    output logic [VAL_W+2:0]           best_value,
    output logic [WT_W+2:0]            best_weight
);

    localparam int unsigned SUM_VW = VAL_W + 3;
    localparam int unsigned SUM_WW = WT_W + 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                     state_q;
    logic [N_ITEMS-1:0]         cnt_q;
    logic [N_ITEMS*VAL_W-1:0]   vals_q;
    logic [N_ITEMS*WT_W-1:0]    wts_q;
    logic [SUM_VW-1:0]          min_q;
    logic [SUM_WW-1:0]          maxw_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       found_q;
    logic [N_ITEMS-1:0]         sel_q;
    logic [SUM_VW-1:0]          val_q;
    logic [SUM_WW-1:0]          wt_q;

    logic [SUM_VW-1:0]          val_acc [N_ITEMS+1];
    logic [SUM_WW-1:0]          wt_acc  [N_ITEMS+1];
    logic                       cand_ok;
    logic                       cand_better;
    logic                       last_cand;

    // Running totals of the items selected by the current candidate
    assign val_acc[0] = '0;
    assign wt_acc[0]  = '0;
    for (genvar g = 0; g < N_ITEMS; g++) begin : g_sum
        assign val_acc[g+1] = val_acc[g] +
            (cnt_q[g] ? SUM_VW'(vals_q[g*VAL_W +: VAL_W]) : SUM_VW'(0));
        assign wt_acc[g+1]  = wt_acc[g] +
            (cnt_q[g] ? SUM_WW'(wts_q[g*WT_W +: WT_W]) : SUM_WW'(0));
    end

    assign cand_ok     = (val_acc[N_ITEMS] >= min_q) && (wt_acc[N_ITEMS] <= maxw_q);
    assign cand_better = cand_ok && (!found_q || (val_acc[N_ITEMS] > val_q) ||
                         ((val_acc[N_ITEMS] == val_q) && (wt_acc[N_ITEMS] < wt_q)));
    assign last_cand   = (cnt_q == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vals_q  <= '0;
            wts_q   <= '0;
            min_q   <= '0;
            maxw_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            sel_q   <= '0;
            val_q   <= '0;
            wt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        vals_q  <= item_values;
                        wts_q   <= item_weights;
                        min_q   <= min_value;
                        maxw_q  <= max_weight;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                        sel_q   <= '0;
                        val_q   <= '0;
                        wt_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (cand_better) begin
                        found_q <= 1'b1;
                        sel_q   <= cnt_q;
                        val_q   <= val_acc[N_ITEMS];
                        wt_q    <= wt_acc[N_ITEMS];
                    end
`ifdef KNAP_EARLY_EXIT_EN
                    if (last_cand || cand_ok) begin
`else
                    if (last_cand) begin
`endif
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + N_ITEMS'(1);
                    end
                end
                S_DONE: begin
                    // start is deliberately not sampled on the way back to IDLE
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign best_sel    = sel_q;
    assign best_value  = val_q;
    assign best_weight = wt_q;

endmodule

// File: tb/tb_knap_search.sv
// Self-checking bench for knap_search: subset-enumeration reference model plus per-cycle compare.
module tb_knap_search;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [39:0] item_values = '0;
    logic [39:0] item_weights = '0;
    logic [10:0] min_value = '0;
    logic [10:0] max_weight = '0;
    logic        busy, done, found;
    logic [4:0]  best_sel;
    logic [10:0] best_value, best_weight;

    int n_chk = 0;
    int n_pass = 0;

    knap_search dut (
        .clk(clk), .rst(rst), .start(start),
        .item_values(item_values), .item_weights(item_weights),
        .min_value(min_value), .max_weight(max_weight),
        .busy(busy), .done(done), .found(found),
        .best_sel(best_sel), .best_value(best_value), .best_weight(best_weight)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: try every subset; lat = edges from accept to the done pulse
    function automatic void model(input logic [39:0] v, input logic [39:0] w,
                                  input int minv, input int maxw,
                                  output bit f, output int sel, output int bv,
                                  output int bw, output int lat);
        int tv, tw;
        bit stop;
        f = 0; sel = 0; bv = 0; bw = 0; lat = 32; stop = 0;
        for (int k = 0; k < 32; k++) begin
            tv = 0; tw = 0;
            for (int i = 0; i < 5; i++) begin
                if (((k >> i) & 1) == 1) begin
                    tv += int'(v[i*8 +: 8]);
                    tw += int'(w[i*8 +: 8]);
                end
            end
            if (!stop && tv >= minv && tw <= maxw) begin
`ifdef KNAP_EARLY_EXIT_EN
                f = 1; sel = k; bv = tv; bw = tw; lat = k + 1; stop = 1;
`else
                if (!f || tv > bv || (tv == bv && tw < bw)) begin
                    f = 1; sel = k; bv = tv; bw = tw;
                end
`endif
            end
        end
    endfunction

    // Model state, advanced on each rising edge
    int  edge_n = 0;
    int  m_acc = 0, m_lat = 0, m_idle_from = 0;
    bit  m_ready = 0, m_active = 0, m_zero = 0;
    bit  m_f;
    int  m_sel, m_bv, m_bw;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_ready = 1; m_active = 0; m_zero = 1;
            m_idle_from = edge_n + 1;
        end else if (start && edge_n >= m_idle_from) begin
            model(item_values, item_weights, int'(min_value), int'(max_weight),
                  m_f, m_sel, m_bv, m_bw, m_lat);
            m_acc = edge_n; m_active = 1; m_zero = 0;
            m_idle_from = edge_n + m_lat + 2;
        end
    end

    // Compare every cycle away from the active edge
    always @(negedge clk) begin
        if (m_ready) begin
            check("busy", 32'(busy), 32'(m_active && edge_n <= m_acc + m_lat));
            check("done", 32'(done), 32'(m_active && edge_n == m_acc + m_lat));
            if (m_zero) begin
                check("found_rst", 32'(found), 32'd0);
                check("sel_rst", 32'(best_sel), 32'd0);
                check("val_rst", 32'(best_value), 32'd0);
                check("wt_rst", 32'(best_weight), 32'd0);
            end else if (m_active && edge_n >= m_acc + m_lat) begin
                check("found", 32'(found), 32'(m_f));
                check("best_sel", 32'(best_sel), 32'(m_sel));
                check("best_value", 32'(best_value), 32'(m_bv));
                check("best_weight", 32'(best_weight), 32'(m_bw));
            end
        end
    end

    // One search; dc = cycle of done relative to the start cycle (0 if none)
    task automatic run_search(input logic [39:0] v, input logic [39:0] w,
                              input logic [10:0] mn, input logic [10:0] mx,
                              input int st2_cyc, input int rst_cyc, input bit rnd,
                              output int dc);
        @(negedge clk);
        item_values = v; item_weights = w; min_value = mn; max_weight = mx;
        start = 1'b1;
        dc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst = 1'b0;
            if (done && dc == 0) dc = c;
            if (c == 5 && st2_cyc != 0) start = 1'b1;
            if (c == st2_cyc) start = 1'b1;
            if (rnd && dc == 0) begin
                item_values = {$urandom, $urandom};
                item_weights = {$urandom, $urandom};
                min_value = 11'($urandom);
                max_weight = 11'($urandom);
                if (c >= 2 && (rst_cyc == 0 || c < rst_cyc) && $urandom_range(0, 7) == 0)
                    start = 1'b1;
            end
            if (c == rst_cyc) rst = 1'b1;
            if (dc != 0 && c > dc) break;
        end
        start = 1'b0;
        rst = 1'b0;
        if (rst_cyc == 0) check("done_seen", 32'(dc != 0), 32'd1);
    endtask

    localparam logic [39:0] VALS = {8'd10, 8'd1, 8'd2, 8'd2, 8'd4};
    localparam logic [39:0] WTS  = {8'd4, 8'd1, 8'd2, 8'd1, 8'd12};

    initial begin
        bit f;
        int s, bv, bw, lat, dc, exp_lat;
        int rc;
        logic [39:0] rv, rw;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Pin the model with hand-derived answers
`ifdef KNAP_EARLY_EXIT_EN
        exp_lat = 31;
`else
        exp_lat = 32;
`endif
        model(VALS, WTS, 15, 16, f, s, bv, bw, lat);
        check("model_sel", 32'(s), 32'd30);
        check("model_val", 32'(bv), 32'd15);
        check("model_wt", 32'(bw), 32'd8);
        check("model_lat", 32'(lat), 32'(exp_lat));
        model(VALS, WTS, 200, 16, f, s, bv, bw, lat);
        check("model_nf", 32'(f), 32'd0);
        model(VALS, WTS, 0, 0, f, s, bv, bw, lat);
        check("model_zero_f", 32'(f), 32'd1);
        check("model_zero_sel", 32'(s), 32'd0);

        // Nominal search with ignored starts mid-search and in the DONE cycle
        run_search(VALS, WTS, 11'd15, 11'd16, exp_lat + 1, 0, 1'b0, dc);
        check("dut_done_cyc", 32'(dc), 32'(exp_lat + 1));
        check("dut_sel", 32'(best_sel), 32'd30);
        check("dut_val", 32'(best_value), 32'd15);
        check("dut_wt", 32'(best_weight), 32'd8);
        repeat (3) @(negedge clk);

        run_search(VALS, WTS, 11'd0, 11'd0, 0, 0, 1'b0, dc);
        check("zero_found", 32'(found), 32'd1);
        check("zero_sel", 32'(best_sel), 32'd0);
        repeat (2) @(negedge clk);

        run_search(VALS, WTS, 11'd200, 11'd16, 0, 0, 1'b0, dc);
        check("nf_done_cyc", 32'(dc), 32'd33);
        check("nf_found", 32'(found), 32'd0);
        repeat (2) @(negedge clk);

        // Abort with reset in cycle 10; compare process expects no done
        run_search(VALS, WTS, 11'd15, 11'd16, 0, 10, 1'b0, dc);
        check("abort_no_done", 32'(dc), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);

        // Randomized searches with input churn, stray starts and occasional resets
        for (int n = 0; n < 50; n++) begin
            rv = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            if (n % 3 == 0) rv = rv & 40'h1F1F1F1F1F;
            rc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 30)) : 0;
            run_search(rv, rw, 11'($urandom_range(0, 700)), 11'($urandom_range(0, 700)),
                       0, rc, 1'b1, dc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
